// File: rtl/dfu_boot_helper_pkg.sv
// Shared constants and types for the iCE40 boot/reset helper.
package dfu_boot_helper_pkg;

  // Warm-boot image selects presented on SB_WARMBOOT S1/S0
  localparam logic [1:0] BOOT_IMG_DFU = 2'b01;
  localparam logic [1:0] BOOT_IMG_APP = 2'b10;

  // BTN_MODE bit positions
  localparam int unsigned BTN_INV = 0;
  localparam int unsigned BTN_IOB = 1;

  // Debounce counter geometry
  localparam int unsigned DB_CNT_W = 3;
  localparam logic [DB_CNT_W-1:0] DB_CNT_MAX = '1;

  // Boot latch state; bit0 = armed, bit1 = BOOT pin. 2'b10 is unreachable.
  typedef enum logic [1:0] {
    BS_IDLE  = 2'b00,
    BS_ARMED = 2'b01,
    BS_BOOT  = 2'b11
  } boot_state_e;

endpackage

// File: rtl/dfu_boot_helper_if.sv
// Software/button side signals of the boot helper.
interface dfu_boot_helper_if;

  logic       boot_now;
  logic [1:0] boot_sel;
  logic       btn_pad;
  logic       btn_val;
  logic       rst_req;

  modport master (
    output boot_now,
    output boot_sel,
    output btn_pad,
    input  btn_val,
    input  rst_req
  );

  modport slave (
    input  boot_now,
    input  boot_sel,
    input  btn_pad,
    output btn_val,
    output rst_req
  );

endinterface

// File: rtl/dfu_btn_debounce.sv
// Button input path: optional pulled-up IOB, polarity, 2-FF sync and hysteretic debounce.
module dfu_btn_debounce
  import dfu_boot_helper_pkg::*;
#(
  parameter int unsigned BTN_MODE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pad,
  output logic o_btn_val
);

  logic                w_pad_buf;
  logic                w_pad_lvl;
  logic                w_btn_s;
  logic [1:0]          r_sync;
  logic [DB_CNT_W-1:0] r_cnt;
  logic                r_btn_val;

  // Pad buffer: SB_IO with internal pull-up on silicon, a plain wire in simulation
  generate
    if (BTN_MODE[BTN_IOB]) begin : g_iob
`ifdef SYNTHESIS
      SB_IO #(
        .PIN_TYPE (6'b000001),
        .PULLUP   (1'b1)
      ) u_btn_io (
        .PACKAGE_PIN (i_pad),
        .D_IN_0      (w_pad_buf)
      );
`else
      assign w_pad_buf = i_pad;
`endif
    end else begin : g_wire
      assign w_pad_buf = i_pad;
    end
  endgenerate

  assign w_pad_lvl = BTN_MODE[BTN_INV] ? ~w_pad_buf : w_pad_buf;
  assign w_btn_s   = r_sync[1];

  // Two-stage synchronizer for the asynchronous pad
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], w_pad_lvl};
    end
  end

  // Saturating up/down counter tracking the synchronized level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_btn_s) begin
      if (r_cnt != DB_CNT_MAX) r_cnt <= r_cnt + DB_CNT_W'(1);
    end else begin
      if (r_cnt != '0) r_cnt <= r_cnt - DB_CNT_W'(1);
    end
  end

  // Hysteresis: only the saturated ends of the counter move btn_val
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_val <= 1'b0;
    end else if (r_cnt == DB_CNT_MAX) begin
      r_btn_val <= 1'b1;
    end else if (r_cnt == '0) begin
      r_btn_val <= 1'b0;
    end
  end

  assign o_btn_val = r_btn_val;

endmodule

// File: rtl/dfu_boot_helper.sv
// Boot/reset helper: times debounced presses and turns them, or software
// requests, into an iCE40 warm-boot or a one-cycle reset request.
module dfu_boot_helper
  import dfu_boot_helper_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = 24,
  parameter int unsigned BTN_MODE    = 3,
  parameter int unsigned DFU_MODE    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  dfu_boot_helper_if.slave io_bus
);

  // Which press length boots (the other one resets), and the image it boots
  localparam bit         LONG_BOOTS = (DFU_MODE == 0);
  localparam logic [1:0] PRESS_IMG  = (DFU_MODE == 0) ? BOOT_IMG_DFU : BOOT_IMG_APP;

  logic                   w_btn_val;
  logic                   r_btn_val_d;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic                   w_long;
  logic                   w_release;
  logic                   w_press_boot;
  logic                   w_press_rst;
  logic                   w_idle;
  logic                   w_sw_req;
  logic                   r_rst_req;
  boot_state_e            r_state;
  boot_state_e            w_state_nxt;
  logic [1:0]             r_boot_sel;
  logic [1:0]             w_boot_sel_nxt;

  dfu_btn_debounce #(
    .BTN_MODE (BTN_MODE)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_pad     (io_bus.btn_pad),
    .o_btn_val (w_btn_val)
  );

  // Timer still holds the press length in the cycle the release is seen
  assign w_long       = r_timer[TIMER_WIDTH-1];
  assign w_release    = r_btn_val_d & ~w_btn_val;
  assign w_press_boot = w_release & (w_long == LONG_BOOTS);
  assign w_press_rst  = w_release & (w_long != LONG_BOOTS);
  assign w_idle       = (r_state == BS_IDLE);
  assign w_sw_req     = io_bus.boot_now & w_idle;

  // Press timer: counts while pressed, saturates at MSB, clears on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (!w_btn_val) begin
      r_timer <= '0;
    end else if (!w_long) begin
      r_timer <= r_timer + TIMER_WIDTH'(1);
    end
  end

  // Release edge detect and reset-request pulse; suppressed once a boot is armed or arming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_val_d <= 1'b0;
      r_rst_req   <= 1'b0;
    end else begin
      r_btn_val_d <= w_btn_val;
      r_rst_req   <= w_press_rst & w_idle & ~io_bus.boot_now;
    end
  end

  // Boot latch state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BS_IDLE;
      r_boot_sel <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_boot_sel <= w_boot_sel_nxt;
    end
  end

  // Boot latch next state: software beats a button boot; BOOT rises one clk after S1/S0 settle
  always_comb begin
    w_state_nxt    = r_state;
    w_boot_sel_nxt = r_boot_sel;
    case (r_state)
      BS_IDLE: begin
        if (w_sw_req) begin
          w_state_nxt    = BS_ARMED;
          w_boot_sel_nxt = io_bus.boot_sel;
        end else if (w_press_boot) begin
          w_state_nxt    = BS_ARMED;
          w_boot_sel_nxt = PRESS_IMG;
        end
      end
      BS_ARMED: w_state_nxt = BS_BOOT;
      BS_BOOT:  w_state_nxt = BS_BOOT;
      default:  w_state_nxt = BS_IDLE;
    endcase
  end

`ifdef SYNTHESIS
  // BOOT is state bit1, set only in BS_BOOT, so the pin comes straight off a flop
  SB_WARMBOOT u_warmboot (
    .BOOT (r_state[1]),
    .S1   (r_boot_sel[1]),
    .S0   (r_boot_sel[0])
  );
`endif

  assign io_bus.btn_val = w_btn_val;
  assign io_bus.rst_req = r_rst_req;

endmodule

// File: tb/tb_dfu_boot_helper.sv
// Bench for dfu_boot_helper: two instances (user-app and DFU builds) share
// stimulus; expectations come from press-length arithmetic and event rules.
module tb_dfu_boot_helper;
  import dfu_boot_helper_pkg::*;

  localparam int unsigned TW       = 4;
  localparam int          LONG_LEN = 1 << (TW - 1);
  localparam int          DB_MIN   = 7;
  localparam int          DB_LAT   = 10;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       pad      = 1'b1;
  logic       boot_now = 1'b0;
  logic [1:0] boot_sel = 2'b00;

  int n_assert = 0;
  int n_fail   = 0;

  bit         m_armed [2];
  bit         m_boot  [2];
  logic [1:0] m_img   [2];

  dfu_boot_helper_if bus0 ();
  dfu_boot_helper_if bus1 ();

  assign bus0.btn_pad  = pad;
  assign bus0.boot_now = boot_now;
  assign bus0.boot_sel = boot_sel;
  assign bus1.btn_pad  = pad;
  assign bus1.boot_now = boot_now;
  assign bus1.boot_sel = boot_sel;

  dfu_boot_helper #(.TIMER_WIDTH(TW), .BTN_MODE(1), .DFU_MODE(0)) u_dut0 (
    .clk (clk), .rst_n (rst_n), .io_bus (bus0)
  );
  dfu_boot_helper #(.TIMER_WIDTH(TW), .BTN_MODE(1), .DFU_MODE(1)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .io_bus (bus1)
  );

  always #5 clk = ~clk;

  function automatic logic dut_btn(input int d);
    return (d == 0) ? bus0.btn_val : bus1.btn_val;
  endfunction
  function automatic logic dut_rst(input int d);
    return (d == 0) ? bus0.rst_req : bus1.rst_req;
  endfunction
  function automatic logic dut_boot(input int d);
    return (d == 0) ? (u_dut0.r_state == BS_BOOT) : (u_dut1.r_state == BS_BOOT);
  endfunction
  function automatic logic [1:0] dut_sel(input int d);
    return (d == 0) ? u_dut0.r_boot_sel : u_dut1.r_boot_sel;
  endfunction
  function automatic logic [TW-1:0] dut_timer(input int d);
    return (d == 0) ? u_dut0.r_timer : u_dut1.r_timer;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_armed[d] = 1'b0;
      m_boot[d]  = 1'b0;
      m_img[d]   = 2'b00;
    end
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    pad      = 1'b1;
    boot_now = 1'b0;
    boot_sel = 2'b00;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pad held low for len clks (0 = no press); optional software request sampled at edge sw_at
  task automatic window(input int len, input int sw_at, input logic [1:0] sw_sel, input string name);
    int   d_edge;
    bit   is_long;
    bit   boot_kind;
    bit   exp_btn;
    logic exp_rst [2];
    d_edge  = (len >= DB_MIN) ? len + DB_LAT + 1 : -1;
    is_long = (len >= LONG_LEN);
    @(posedge clk);
    #1;
    if (len > 0) pad = 1'b0;
    for (int k = 1; k <= len + 14; k++) begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        boot_kind  = (d == 0) ? is_long : !is_long;
        exp_rst[d] = 1'b0;
        if (m_armed[d]) begin
          m_boot[d] = 1'b1;
        end else if (sw_at == k) begin
          m_armed[d] = 1'b1;
          m_img[d]   = sw_sel;
        end else if (k == d_edge) begin
          if (boot_kind) begin
            m_armed[d] = 1'b1;
            m_img[d]   = (d == 0) ? BOOT_IMG_DFU : BOOT_IMG_APP;
          end else begin
            exp_rst[d] = 1'b1;
          end
        end
      end
      #1;
      if (k == len) pad = 1'b1;
      if (k == sw_at - 1) begin
        boot_now = 1'b1;
        boot_sel = sw_sel;
      end else if (k == sw_at) begin
        boot_now = 1'b0;
      end
      @(negedge clk);
      exp_btn = (len >= DB_MIN) && (k >= DB_LAT) && (k < len + DB_LAT);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("%s.d%0d.k%0d.btn_val", name, d, k), 32'(dut_btn(d)), 32'(exp_btn));
        chk($sformatf("%s.d%0d.k%0d.rst_req", name, d, k), 32'(dut_rst(d)), 32'(exp_rst[d]));
        chk($sformatf("%s.d%0d.k%0d.boot", name, d, k), 32'(dut_boot(d)), 32'(m_boot[d]));
        chk($sformatf("%s.d%0d.k%0d.s1s0", name, d, k), 32'(dut_sel(d)), 32'(m_img[d]));
      end
    end
  endtask

  initial begin
    int len;
    model_clear();

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset.d%0d.btn_val", d), 32'(dut_btn(d)), 32'd0);
      chk($sformatf("reset.d%0d.rst_req", d), 32'(dut_rst(d)), 32'd0);
      chk($sformatf("reset.d%0d.boot", d), 32'(dut_boot(d)), 32'd0);
      chk($sformatf("reset.d%0d.s1s0", d), 32'(dut_sel(d)), 32'd0);
      chk($sformatf("reset.d%0d.timer", d), 32'(dut_timer(d)), 32'd0);
    end
    apply_reset();

    // Glitches shorter than the debounce length
    window(5, -1, 2'b00, "glitch5");
    window(6, -1, 2'b00, "glitch6");
    for (int i = 0; i < 3; i++) begin
      len = int'($urandom_range(1, 6));
      window(len, -1, 2'b00, $sformatf("glitch_r%0d", i));
    end

    // Shortest press that registers: short for both builds
    window(DB_MIN, -1, 2'b00, "short");
    apply_reset();

    // Random long press
    len = int'($urandom_range(LONG_LEN, 40));
    window(len, -1, 2'b00, "long");
    apply_reset();

    // Boundary: exactly the long threshold
    window(LONG_LEN, -1, 2'b00, "long_min");
    apply_reset();

    // Software request lands on the same edge as the button decode
    len = int'($urandom_range(LONG_LEN, 30));
    window(len, len + DB_LAT + 1, 2'b11, "simul");
    apply_reset();

    // Software boot, then a later request that must be ignored
    window(0, 2, 2'b11, "sw");
    window(0, 3, 2'b00, "sw_again");

    // Reset mid-press with the timer at 6, button held through reset release
    @(posedge clk);
    #1 pad = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("midrst.d%0d.timer", d), 32'(dut_timer(d)), 32'd6);
    rst_n = 1'b0;
    #1;
    model_clear();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midrst.d%0d.btn_val", d), 32'(dut_btn(d)), 32'd0);
      chk($sformatf("midrst.d%0d.rst_req", d), 32'(dut_rst(d)), 32'd0);
      chk($sformatf("midrst.d%0d.boot", d), 32'(dut_boot(d)), 32'd0);
      chk($sformatf("midrst.d%0d.s1s0", d), 32'(dut_sel(d)), 32'd0);
      chk($sformatf("midrst.d%0d.timer", d), 32'(dut_timer(d)), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= DB_LAT; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        chk($sformatf("refresh.d%0d.k%0d.btn_val", d, k), 32'(dut_btn(d)), 32'(k >= DB_LAT));
    end
    apply_reset();
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
